branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Back end of the branch-prediction loop. Queues each fetch-stage prediction in order,
//  compares it with the execute-stage resolution, raises a flush/redirect on mispredict
//  and drives a training-update port back to the predictor.
//  Sits between fetch (branch predictor) and the execute-stage branch comparator.
// PARAMETERS
//  ADDR_LENGTH  22  Width of the word address of an instruction in IMEM.
//  DEPTH        4   In-flight branch entries. Must be a power of 2 and >= 2.
//  CNT_W        3   Occupancy counter width, $clog2(DEPTH+1).
// PORTS
//  i_Clk            in   1            Clock. All state updates on the rising edge.
//  i_Reset_n        in   1            Reset: synchronous, active-low.
//  i_pred_valid     in   1            Fetch presents a predicted branch this cycle.
//  i_pred_addr      in   ADDR_LENGTH  Word address of the branch instruction.
//  i_pred_taken     in   1            Predicted direction (1 = taken).
//  i_pred_target    in   ADDR_LENGTH  Predicted target; ignored when predicted not-taken.
//  o_pred_ready     out  1            Queue can accept an entry (count < DEPTH, no flush).
//  i_res_valid      in   1            Execute resolves the oldest outstanding branch.
//  i_res_taken      in   1            Actual direction.
//  i_res_target     in   ADDR_LENGTH  Actual target; valid when i_res_taken = 1.
//  o_flush          out  1            One-cycle pulse: squash younger instructions.
//  o_redirect_addr  out  ADDR_LENGTH  Correct fetch address; valid while o_flush = 1.
//  o_upd_valid      out  1            One-cycle pulse: train the predictor.
//  o_upd_addr       out  ADDR_LENGTH  Branch address that is being trained.
//  o_upd_taken      out  1            Actual outcome for training.
//  o_count          out  CNT_W        Current queue occupancy.
//  o_error          out  1            One-cycle pulse: resolution arrived with an empty queue.
// BEHAVIOUR
//  - Reset (i_Reset_n = 0 at an edge): pointers, count and every output go to 0;
//    o_pred_ready goes to 1. Reset wins over all other inputs.
//    A reset during an outstanding mispredict cancels the pending flush.
//  - Push: an entry {addr, taken, target} is written when i_pred_valid && o_pred_ready.
//    A push without ready is dropped. Fetch is responsible for stalling.
//  - Resolve: when i_res_valid && count > 0, the head entry is popped and compared.
//    Mispredict = (pred_taken != res_taken) || (res_taken && pred_target != res_target).
//  - Outputs are registered, with one-cycle latency from i_res_valid.
//    o_upd_valid = 1 and o_upd_taken = res_taken for every pop.
//    On a mispredict, also o_flush = 1 and o_redirect_addr = res_taken ? res_target : addr+1.
//    addr+1 wraps modulo 2^ADDR_LENGTH.
//  - Flush: in the detecting cycle the whole queue is cleared (count := 0) and any
//    simultaneous push is discarded, because it is on the wrong path.
//    o_pred_ready = 0 in the cycle o_flush is high. Normal operation resumes the next cycle.
//  - Simultaneous push and correct pop: count is unchanged and both pointers advance.
//    Full and resolving in the same cycle: ready stays 0, with no bypass.
//  - Empty and i_res_valid: no pop, o_error pulses, o_flush and o_upd_valid stay 0.
//  - Pointers are log2(DEPTH) bits and wrap naturally. Full = count==DEPTH; empty = count==0.
//  - All pulses are deasserted the following cycle unless retriggered.
// STRUCTURE
//  - Shared package mips_bp_pkg: entry field offsets and widths, plus the
//    BR_ENTRY_W = 2*ADDR_LENGTH+1 constant.
//  - One sub-module: bru_fifo (sync FIFO with a clear input, push/pop, count).
//    The compare, flush and update logic stays in this module.
// TESTING
//  1. Reset, then push addr 0x10 taken target 0x40 and resolve taken 0x40
//     -> o_upd_valid=1, o_upd_taken=1, o_flush=0, count returns to 0.
//  2. Push addr 0x20 not-taken and resolve taken target 0x80
//     -> next cycle o_flush=1, o_redirect=0x80, count=0.
//  3. Push addr 0x30 taken target 0x50 and resolve taken target 0x60
//     -> o_flush=1, o_redirect=0x60 (target mismatch).
//  4. Push addr 0x3FFFFF taken and resolve not-taken -> o_redirect=0x000000 (wrap).
//  5. Push 4 entries -> o_pred_ready=0 and a 5th push is dropped.
//     Push+pop in one cycle at count 2 -> count stays 2. Mispredict with a push the
//     same cycle -> count=0 and the pushed entry is lost.
//  6. Resolve with an empty queue -> o_error=1, no update.
//     Assert i_Reset_n=0 in the mispredict cycle -> no o_flush next cycle, all outputs 0.

Source files
------------

// File: rtl/mips_bp_pkg.sv
// Shared constants for the branch-resolve path: entry layout and widths.
package mips_bp_pkg;

  localparam int unsigned BP_ADDR_LENGTH = 22;
  localparam int unsigned BR_ENTRY_W     = 2 * BP_ADDR_LENGTH + 1;

  // Entry layout, MSB to LSB: {addr, taken, target}
  localparam int unsigned BR_TGT_LSB = 0;

  function automatic int unsigned br_entry_w(input int unsigned aw);
    return 2 * aw + 1;
  endfunction

  function automatic int unsigned br_taken_bit(input int unsigned aw);
    return aw;
  endfunction

  function automatic int unsigned br_addr_lsb(input int unsigned aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/bru_fifo.sv
// In-order branch entry queue: synchronous FIFO with clear, push, pop and occupancy.
module bru_fifo
  import mips_bp_pkg::*;
#(
  parameter int unsigned WIDTH = BR_ENTRY_W,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             i_Clk,
  input  logic             i_Reset_n,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Caller only pushes when not full and pops when not empty.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_push && !i_clr) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/branch_resolve_unit.sv
// Matches fetch predictions against execute resolutions in order; flushes on mispredict
// and drives predictor training updates.
module branch_resolve_unit
  import mips_bp_pkg::*;
#(
  parameter int unsigned ADDR_LENGTH = BP_ADDR_LENGTH,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned CNT_W       = 3
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset_n,
  input  logic                   i_pred_valid,
  input  logic [ADDR_LENGTH-1:0] i_pred_addr,
  input  logic                   i_pred_taken,
  input  logic [ADDR_LENGTH-1:0] i_pred_target,
  output logic                   o_pred_ready,
  input  logic                   i_res_valid,
  input  logic                   i_res_taken,
  input  logic [ADDR_LENGTH-1:0] i_res_target,
  output logic                   o_flush,
  output logic [ADDR_LENGTH-1:0] o_redirect_addr,
  output logic                   o_upd_valid,
  output logic [ADDR_LENGTH-1:0] o_upd_addr,
  output logic                   o_upd_taken,
  output logic [CNT_W-1:0]       o_count,
  output logic                   o_error
);

  localparam int unsigned ENTRY_W   = br_entry_w(ADDR_LENGTH);
  localparam int unsigned TAKEN_BIT = br_taken_bit(ADDR_LENGTH);
  localparam int unsigned ADDR_LSB  = br_addr_lsb(ADDR_LENGTH);

  logic [ENTRY_W-1:0]     w_head;
  logic [ADDR_LENGTH-1:0] w_h_addr;
  logic [ADDR_LENGTH-1:0] w_h_target;
  logic                   w_h_taken;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_mispred;
  logic                   w_push;

  logic                   r_flush;
  logic [ADDR_LENGTH-1:0] r_redirect;
  logic                   r_upd_valid;
  logic [ADDR_LENGTH-1:0] r_upd_addr;
  logic                   r_upd_taken;
  logic                   r_error;

  assign w_h_addr   = w_head[ADDR_LSB +: ADDR_LENGTH];
  assign w_h_taken  = w_head[TAKEN_BIT];
  assign w_h_target = w_head[BR_TGT_LSB +: ADDR_LENGTH];

  assign w_pop     = i_res_valid && !w_empty;
  assign w_mispred = w_pop && ((w_h_taken != i_res_taken) ||
                               (i_res_taken && (w_h_target != i_res_target)));
  // A push alongside a mispredict is on the wrong path and is discarded.
  assign w_push       = i_pred_valid && o_pred_ready && !w_mispred;
  assign o_pred_ready = !w_full && !r_flush;

  bru_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo (
    .i_Clk    (i_Clk),
    .i_Reset_n(i_Reset_n),
    .i_clr    (w_mispred),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_data   ({i_pred_addr, i_pred_taken, i_pred_target}),
    .o_head   (w_head),
    .o_count  (o_count),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      r_flush     <= 1'b0;
      r_redirect  <= '0;
      r_upd_valid <= 1'b0;
      r_upd_addr  <= '0;
      r_upd_taken <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_flush     <= w_mispred;
      r_upd_valid <= w_pop;
      r_error     <= i_res_valid && w_empty;
      if (w_pop) begin
        r_upd_addr  <= w_h_addr;
        r_upd_taken <= i_res_taken;
      end
      if (w_mispred)
        r_redirect <= i_res_taken ? i_res_target : w_h_addr + ADDR_LENGTH'(1);
    end
  end

  assign o_flush         = r_flush;
  assign o_redirect_addr = r_redirect;
  assign o_upd_valid     = r_upd_valid;
  assign o_upd_addr      = r_upd_addr;
  assign o_upd_taken     = r_upd_taken;
  assign o_error         = r_error;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Table-driven scoreboard bench for branch_resolve_unit.
module tb_branch_resolve_unit;

  localparam int unsigned AW = 22;

  typedef struct {
    string       name;
    logic        rst_n;
    logic        pv;
    logic [AW-1:0] pa;
    logic        pt;
    logic [AW-1:0] ptg;
    logic        rv;
    logic        rt;
    logic [AW-1:0] rtg;
    logic        e_ready;
    logic [2:0]  e_count;
    logic        e_upd;
    logic [AW-1:0] e_uaddr;
    logic        e_utaken;
    logic        e_flush;
    logic [AW-1:0] e_redir;
    logic        e_err;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pv = 1'b0, pt = 1'b0, rv = 1'b0, rt = 1'b0;
  logic [AW-1:0] pa = '0, ptg = '0, rtg = '0;
  logic          ready, flush, upd_valid, upd_taken, err;
  logic [AW-1:0] redir, upd_addr;
  logic [2:0]    count;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  branch_resolve_unit #(.ADDR_LENGTH(AW), .DEPTH(4), .CNT_W(3)) dut (
    .i_Clk          (clk),
    .i_Reset_n      (rst_n),
    .i_pred_valid   (pv),
    .i_pred_addr    (pa),
    .i_pred_taken   (pt),
    .i_pred_target  (ptg),
    .o_pred_ready   (ready),
    .i_res_valid    (rv),
    .i_res_taken    (rt),
    .i_res_target   (rtg),
    .o_flush        (flush),
    .o_redirect_addr(redir),
    .o_upd_valid    (upd_valid),
    .o_upd_addr     (upd_addr),
    .o_upd_taken    (upd_taken),
    .o_count        (count),
    .o_error        (err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input string name, input logic r, input logic ipv,
                              input logic [AW-1:0] ipa, input logic ipt, input logic [AW-1:0] iptg,
                              input logic irv, input logic irt, input logic [AW-1:0] irtg,
                              input logic erdy, input logic [2:0] ecnt, input logic eupd,
                              input logic [AW-1:0] eua, input logic eut, input logic efl,
                              input logic [AW-1:0] ered, input logic eerr);
    vec_t v;
    v.name = name; v.rst_n = r; v.pv = ipv; v.pa = ipa; v.pt = ipt; v.ptg = iptg;
    v.rv = irv; v.rt = irt; v.rtg = irtg; v.e_ready = erdy; v.e_count = ecnt;
    v.e_upd = eupd; v.e_uaddr = eua; v.e_utaken = eut; v.e_flush = efl;
    v.e_redir = ered; v.e_err = eerr;
    return v;
  endfunction

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%0h, want 0x%0h", nm, fld, act, expv);
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    rst_n = v.rst_n; pv = v.pv; pa = v.pa; pt = v.pt; ptg = v.ptg;
    rv = v.rv; rt = v.rt; rtg = v.rtg;
    exp_q.push_back(v);
    @(posedge clk);
  endtask

  // Idle / push / resolve helpers building one cycle of stimulus plus expectations
  task automatic push(input string nm, input logic [AW-1:0] a, input logic t,
                      input logic [AW-1:0] tg, input logic erdy, input logic [2:0] ecnt);
    step(mk(nm, 1, 1, a, t, tg, 0, 0, 0, erdy, ecnt, 0, 0, 0, 0, 0, 0));
  endtask

  always @(posedge clk) begin
    vec_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.name, "ready", 32'(ready), 32'(e.e_ready));
      chk(e.name, "count", 32'(count), 32'(e.e_count));
      chk(e.name, "upd_valid", 32'(upd_valid), 32'(e.e_upd));
      chk(e.name, "flush", 32'(flush), 32'(e.e_flush));
      chk(e.name, "error", 32'(err), 32'(e.e_err));
      if (e.e_upd || !e.rst_n) begin
        chk(e.name, "upd_addr", 32'(upd_addr), 32'(e.e_uaddr));
        chk(e.name, "upd_taken", 32'(upd_taken), 32'(e.e_utaken));
      end
      if (e.e_flush || !e.rst_n)
        chk(e.name, "redirect", 32'(redir), 32'(e.e_redir));
    end
  end

  initial begin
    //          name       rst pv pa        pt ptg     rv rt rtg     rdy cnt upd uaddr     ut fl redir   err
    tbl.push_back(mk("rst0",  0, 0, 0,        0, 0,      0, 0, 0,      1, 0, 0, 0,        0, 0, 0,      0));
    tbl.push_back(mk("rst1",  0, 1, 'h55,     1, 'h66,   1, 1, 'h77,   1, 0, 0, 0,        0, 0, 0,      0));
    tbl.push_back(mk("t1push",1, 1, 'h10,     1, 'h40,   0, 0, 0,      1, 1, 0, 0,        0, 0, 0,      0));
    tbl.push_back(mk("t1res", 1, 0, 0,        0, 0,      1, 1, 'h40,   1, 0, 1, 'h10,     1, 0, 0,      0));
    tbl.push_back(mk("t2push",1, 1, 'h20,     0, 0,      0, 0, 0,      1, 1, 0, 0,        0, 0, 0,      0));
    tbl.push_back(mk("t2res", 1, 0, 0,        0, 0,      1, 1, 'h80,   0, 0, 1, 'h20,     1, 1, 'h80,   0));
    tbl.push_back(mk("t2idle",1, 0, 0,        0, 0,      0, 0, 0,      1, 0, 0, 0,        0, 0, 0,      0));
    tbl.push_back(mk("t3push",1, 1, 'h30,     1, 'h50,   0, 0, 0,      1, 1, 0, 0,        0, 0, 0,      0));
    tbl.push_back(mk("t3res", 1, 0, 0,        0, 0,      1, 1, 'h60,   0, 0, 1, 'h30,     1, 1, 'h60,   0));
    tbl.push_back(mk("t3idle",1, 0, 0,        0, 0,      0, 0, 0,      1, 0, 0, 0,        0, 0, 0,      0));
    tbl.push_back(mk("t4push",1, 1, 'h3FFFFF, 1, 'h100,  0, 0, 0,      1, 1, 0, 0,        0, 0, 0,      0));
    tbl.push_back(mk("t4res", 1, 0, 0,        0, 0,      1, 0, 0,      0, 0, 1, 'h3FFFFF, 0, 1, 'h0,    0));
    tbl.push_back(mk("t4idle",1, 0, 0,        0, 0,      0, 0, 0,      1, 0, 0, 0,        0, 0, 0,      0));
    tbl.push_back(mk("ntpush",1, 1, 'h44,     0, 'h123,  0, 0, 0,      1, 1, 0, 0,        0, 0, 0,      0));
    tbl.push_back(mk("ntres", 1, 0, 0,        0, 0,      1, 0, 'h999,  1, 0, 1, 'h44,     0, 0, 0,      0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Fill to full, then a dropped fifth push
    for (int unsigned k = 0; k < 4; k++)
      push($sformatf("fill%0d", k), AW'('h100 + k), 1, AW'('h200 + k), (k < 3), 3'(k + 1));
    push("drop5", 'h1FF, 1, 'h2FF, 0, 4);
    step(mk("fullres", 1, 1, 'h1EE, 1, 'h2EE, 1, 1, 'h200, 1, 3, 1, 'h100, 1, 0, 0, 0));
    step(mk("res101",  1, 0, 0,     0, 0,     1, 1, 'h201, 1, 2, 1, 'h101, 1, 0, 0, 0));
    step(mk("pushpop", 1, 1, 'h150, 1, 'h250, 1, 1, 'h202, 1, 2, 1, 'h102, 1, 0, 0, 0));
    step(mk("misppush",1, 1, 'h160, 1, 'h260, 1, 0, 0,     0, 0, 1, 'h103, 0, 1, 'h104, 0));
    step(mk("flushcyc",1, 1, 'h170, 1, 'h270, 0, 0, 0,     1, 0, 0, 0,     0, 0, 0, 0));
    step(mk("emptyres",1, 0, 0,     0, 0,     1, 1, 'h150, 1, 0, 0, 0,     0, 0, 0, 1));
    step(mk("errclr",  1, 0, 0,     0, 0,     0, 0, 0,     1, 0, 0, 0,     0, 0, 0, 0));

    // Reset in the mispredict cycle cancels the flush
    push("t6push", 'h300, 1, 'h310, 1, 1);
    step(mk("t6rst",   0, 0, 0,     0, 0,     1, 0, 0,     1, 0, 0, 0,     0, 0, 0, 0));
    step(mk("t6after", 1, 0, 0,     0, 0,     0, 0, 0,     1, 0, 0, 0,     0, 0, 0, 0));

    @(negedge clk);
    rv = 1'b0; pv = 1'b0;
    for (int unsigned w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
